// File: rtl/serial_tx_engine.sv
// serial_tx_engine: pops 9-bit words from the TX FIFO and frames them as start/data/parity/stop on tx
//   S_AXI_ACLK, S_AXI_ARESETN : clock, asynchronous active-low reset
//   control : [0] enable, [3:1] size code, [5:4] parity, [6] two stop bits, [7] break
//   brd     : baud divisor, [31:8] integer N, [7:0] fraction f
//   fifo_empty, fifo_rd_data, fifo_rd_request : FIFO head, pop strobe
//   tx, busy, tx_done : serial line, frame in progress, last-cycle-of-frame pulse
module serial_tx_engine #(
  parameter int MIN_DIV = 2
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic [31:0] control,
  input  logic [31:0] brd,
  input  logic        fifo_empty,
  input  logic [8:0]  fifo_rd_data,
  output logic        fifo_rd_request,
  output logic        tx,
  output logic        busy,
  output logic        tx_done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t      state_q, state_d;
  logic [8:0]  sh_q, sh_d;
  logic [23:0] cnt_q, cnt_d, n_q, n_d;
  logic [7:0]  acc_q, acc_d, f_q, f_d;
  logic [3:0]  d_q, d_d, bits_q, bits_d;
  logic        par_q, par_d, pen_q, pen_d, two_q, two_d, tx_q, tx_d;
  logic        elig, bit_end, last, nb;
  logic [3:0]  dsz;
  logic [8:0]  dmask, sum;
  logic        unused;
  assign unused = ^control[31:8];
  assign dsz = control[3:1] <= 3'd4 ? 4'(control[3:1]) + 4'd5 : 4'd8;
  assign dmask = 9'h1FF >> (4'd9 - dsz);
  // reset gating keeps the pop strobe quiet while the state is held in IDLE by reset
  assign elig = S_AXI_ARESETN & control[0] & ~fifo_empty & (brd[31:8] >= 24'(MIN_DIV)) & ~control[7];
  assign bit_end = state_q != IDLE && cnt_q == 24'd0;
  assign last = state_q == STOP && bit_end && bits_q == 4'd0;
  assign fifo_rd_request = elig && (state_q == IDLE || last);
  assign tx_done = last;
  assign busy = state_q != IDLE;
  assign tx = tx_q;
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    bits_d = bits_q;
    n_d = n_q;
    f_d = f_q;
    d_d = d_q;
    par_d = par_q;
    pen_d = pen_q;
    two_d = two_q;
    acc_d = acc_q;
    nb = 1'b0;
    cnt_d = cnt_q == 24'd0 ? cnt_q : cnt_q - 24'd1;
    if (fifo_rd_request) begin
      state_d = START;
      sh_d = fifo_rd_data;
      n_d = brd[31:8];
      f_d = brd[7:0];
      d_d = dsz;
      pen_d = control[5] ^ control[4];
      par_d = ^(fifo_rd_data & dmask) ^ (control[5:4] == 2'b10);
      two_d = control[6];
      nb = 1'b1;
    end else if (bit_end) begin
      unique case (state_q)
        START: begin
          state_d = DATA;
          bits_d = d_q - 4'd1;
          nb = 1'b1;
        end
        DATA: begin
          sh_d = sh_q >> 1;
          state_d = bits_q != 4'd0 ? DATA : pen_q ? PARITY : STOP;
          bits_d = bits_q != 4'd0 ? bits_q - 4'd1 : {3'd0, two_q};
          nb = 1'b1;
        end
        PARITY: begin
          state_d = STOP;
          bits_d = {3'd0, two_q};
          nb = 1'b1;
        end
        STOP: begin
          state_d = bits_q != 4'd0 ? STOP : IDLE;
          bits_d = bits_q != 4'd0 ? bits_q - 4'd1 : 4'd0;
          nb = bits_q != 4'd0;
        end
        default: ;
      endcase
    end
    // the fraction accumulator restarts from zero on every pop
    sum = {1'b0, fifo_rd_request ? 8'd0 : acc_q} + {1'b0, f_d};
    if (nb) begin
      acc_d = sum[7:0];
      cnt_d = n_d - 24'd1 + {23'd0, sum[8]};
    end
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par_d :
           state_d == STOP ? 1'b1 : ~control[7];
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
      sh_q <= '0;
      cnt_q <= '0;
      n_q <= '0;
      acc_q <= '0;
      f_q <= '0;
      d_q <= '0;
      bits_q <= '0;
      par_q <= 1'b0;
      pen_q <= 1'b0;
      two_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      acc_q <= acc_d;
      f_q <= f_d;
      d_q <= d_d;
      bits_q <= bits_d;
      par_q <= par_d;
      pen_q <= pen_d;
      two_q <= two_d;
      tx_q <= tx_d;
    end
  end
endmodule

// File: tb/tb_serial_tx_engine.sv
// tb_serial_tx_engine: randomized and directed checks of serial_tx_engine against a per-cycle waveform model
module tb_serial_tx_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] control, brd;
  logic        fifo_empty;
  logic [8:0]  fifo_rd_data;
  logic        req, tx, busy, done;
  logic [8:0]  fq[$];
  logic        mq[$];
  int          pops[$];
  int          total = 0, passed = 0, cyc = 0, pop_cyc = 0, done_cyc = 0, busy_cnt = 0, p0;
  logic        idle_tx = 1'b1, pend = 1'b0, last_busy;

  serial_tx_engine dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .control(control), .brd(brd),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_request(req),
    .tx(tx), .busy(busy), .tx_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic a, input logic e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s cyc=%0d got=%0b exp=%0b", n, cyc, a, e);
  endtask

  task automatic chki(input string n, input int a, input int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s got=%0d exp=%0d", n, a, e);
  endtask

  task automatic upd();
    fifo_empty = fq.size() == 0;
    fifo_rd_data = fq.size() != 0 ? fq[0] : 9'd0;
  endtask

  task automatic push(input logic [8:0] w);
    fq.push_back(w);
    upd();
  endtask

  // expected tx level for every cycle of a frame, built bit by bit from the frame rules
  function automatic void build(input logic [8:0] w, input logic [31:0] c, input logic [31:0] b);
    int d = c[3:1] <= 3'd4 ? int'(c[3:1]) + 5 : 8;
    int s = c[6] ? 2 : 1;
    int n = int'(b[31:8]);
    int f = int'(b[7:0]);
    int acc = 0;
    int dur;
    logic par = 1'b0;
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < d; i++) begin
      bits.push_back(w[i]);
      par ^= w[i];
    end
    if (c[5:4] == 2'b01) bits.push_back(par);
    if (c[5:4] == 2'b10) bits.push_back(~par);
    for (int i = 0; i < s; i++) bits.push_back(1'b1);
    foreach (bits[k]) begin
      acc += f;
      dur = n + (acc >= 256 ? 1 : 0);
      acc %= 256;
      repeat (dur) mq.push_back(bits[k]);
    end
  endfunction

  task automatic step();
    logic el, ep, et;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_req", req, 1'b0);
      chk("rst_done", done, 1'b0);
      mq.delete();
      idle_tx = 1'b1;
      pend = 1'b0;
    end else begin
      el = control[0] && !fifo_empty && brd[31:8] >= 24'd2 && !control[7];
      ep = el && mq.size() <= 1;
      et = mq.size() != 0 ? mq[0] : idle_tx;
      chk("tx", tx, et);
      chk("busy", busy, mq.size() != 0);
      chk("req", req, ep);
      chk("done", done, mq.size() == 1);
      if (req) begin
        pop_cyc = cyc;
        pops.push_back(cyc);
      end
      if (done) done_cyc = cyc;
      if (busy) busy_cnt++;
      last_busy = busy;
      if (mq.size() != 0) void'(mq.pop_front());
      if (ep) build(fifo_rd_data, control, brd);
      idle_tx = ~control[7];
      pend = ep;
    end
    @(posedge clk);
    #1;
    if (pend) void'(fq.pop_front());
    pend = 1'b0;
    upd();
  endtask

  task automatic run(input int budget);
    int i = 0;
    step();
    while (mq.size() != 0 && i < budget) begin
      step();
      i++;
    end
    if (mq.size() != 0) begin
      total++;
      $display("FAIL run_timeout cyc=%0d remaining=%0d", cyc, mq.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    control = 32'd0;
    brd = 32'd0;
    upd();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    control = 32'h7; brd = 32'h400; push(9'h055);
    run(100);
    chki("t1_len", done_cyc - pop_cyc, 40);
    step();
    chk("t1_busy_after", last_busy, 1'b0);
    chki("t1_gap", cyc - pop_cyc, 41);

    brd = 32'h480; push(9'h0FF);
    run(100);
    chki("t2_len", done_cyc - pop_cyc, 45);
    step();

    control = 32'h59; brd = 32'h200; push(9'h1A5);
    step();
    chki("t3_model_len", mq.size(), 26);
    chk("t3_model_par", mq.size() > 20 ? mq[20] : 1'b0, 1'b1);
    run(100);
    chki("t3_len", done_cyc - pop_cyc, 26);
    step();

    control = 32'h7; brd = 32'h300;
    p0 = pops.size();
    busy_cnt = 0;
    push(9'h011); push(9'h122); push(9'h033);
    run(200);
    chki("t4_pops", pops.size() - p0, 3);
    if (pops.size() - p0 == 3) begin
      chki("t4_gap1", pops[p0 + 1] - pops[p0], 30);
      chki("t4_gap2", pops[p0 + 2] - pops[p0 + 1], 30);
    end
    chki("t4_busy", busy_cnt, 90);
    step();

    brd = 32'h400; push(9'h0A5); push(9'h15A);
    repeat (10) step();
    control = 32'h6; brd = 32'h100;
    run(100);
    repeat (20) step();
    chki("t5_hold_dis", fq.size(), 1);
    control = 32'h7;
    repeat (20) step();
    chki("t5_hold_n1", fq.size(), 1);
    brd = 32'h400;
    run(100);
    step();

    p0 = pops.size();
    push(9'h0C3); push(9'h03C);
    repeat (12) step();
    rst_n = 1'b0;
    #1;
    chk("t6_async_tx", tx, 1'b1);
    chk("t6_async_busy", busy, 1'b0);
    mq.delete();
    repeat (2) step();
    rst_n = 1'b1;
    run(100);
    chki("t6_pops", pops.size() - p0, 2);
    chki("t6_fifo", fq.size(), 0);
    step();

    for (int it = 0; it < 60; it++) begin
      control = {24'd0, ($urandom_range(0, 9) == 0), 1'($urandom), 2'($urandom), 3'($urandom),
                 ($urandom_range(0, 7) != 0)};
      brd = {24'($urandom_range(0, 5)), 8'($urandom)};
      repeat ($urandom_range(0, 3)) if (fq.size() < 8) push(9'($urandom));
      repeat ($urandom_range(1, 60)) step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
